lsu_mem_master: RTL and testbench

//  - MEM-stage load/store initiator driving the word-wide, big-endian data_mem port (address, writeData, memwrite, memread, out32).
//  - Accepts one load/store request from the pipeline and performs the memory access, including byte/halfword read-modify-write.
//  - Returns aligned, sign/zero-extended load data with a done pulse; holds busy high so the hazard unit can stall.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_mem_master_lane_align.sv | 43 ++++
 rtl/lsu_mem_master.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store master: access sizes, FSM states, lane offsets.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;
  localparam logic [1:0] OFF_H0 = 2'd0;
  localparam logic [1:0] OFF_H1 = 2'd2;

  // Big-endian: byte offset k lives at bits [31-8k -: 8], i.e. LSB at 24-8k.
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    logic [4:0] inv;
    inv = {3'b000, ~off};
    return inv << 3;
  endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational lane steering: extracts/extends a loaded lane and merges store data into an old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lsb;

  always_comb begin
    lsb      = lane_lsb(off_i);
    byte_sel = word_i[lsb +: 8];
    half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
    load_o   = word_i;
    merge_o  = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o = word_i;
        merge_o[lsb +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o = word_i;
        if (off_i[1]) merge_o[15:0]  = wdata_i[15:0];
        else          merge_o[31:16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator for a word-wide big-endian data memory, with sub-word RMW.
// Define LSU_MISALIGN_TRAP_EN to report misaligned/reserved-size requests via rsp_err instead of aligning them.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_out32
);

  state_e            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;

  logic [1:0]  req_off;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_lane_align u_align (
    .word_i     (mem_out32),
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // Offset used for the access: words ignore the low bits, halves ignore bit 0.
  always_comb begin
    case (req_size)
      SZ_BYTE: req_off = req_addr[1:0];
      SZ_HALF: req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    size_d        = size_q;
    uns_d         = uns_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wr_d      = 1'b0;
    mem_rd_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d         = req_off;
          size_d        = req_size;
          uns_d         = req_unsigned;
          we_d          = req_we;
          wdata_d       = req_wdata;
          mem_address_d = {req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
          if ((req_size == SZ_RSVD) ||
              (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
              (req_size == SZ_HALF && req_addr[0])) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else
`endif
          if (!req_we || req_size == SZ_BYTE || req_size == SZ_HALF) begin
            state_d  = RD;
            mem_rd_d = 1'b1;
          end else begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WR;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merge_data;
        end else begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
        end
      end
      WR: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  // Async reset clears the write strobe mid-cycle so an interrupted WR never reaches memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wr_q      <= mem_wr_d;
      mem_rd_q      <= mem_rd_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_wdata_q;
  assign mem_memwrite  = mem_wr_q;
  assign mem_memread   = mem_rd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a behavioural big-endian byte memory.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_out32;

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_out32     (mem_out32)
  );

  always #5 clk = ~clk;

  // Byte-addressed big-endian data memory
  logic [7:0] mem [0:63];
  logic [5:0] ma;
  always_comb begin
    ma = {mem_address[5:2], 2'b00};
    mem_out32 = mem_memread ? {mem[ma], mem[ma + 6'd1], mem[ma + 6'd2], mem[ma + 6'd3]} : 32'h0;
  end
  always @(posedge clk) begin
    if (mem_memwrite) begin
      mem[{mem_address[5:2], 2'b00}]        <= mem_writeData[31:24];
      mem[{mem_address[5:2], 2'b00} + 6'd1] <= mem_writeData[23:16];
      mem[{mem_address[5:2], 2'b00} + 6'd2] <= mem_writeData[15:8];
      mem[{mem_address[5:2], 2'b00} + 6'd3] <= mem_writeData[7:0];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          rd;
    int          wr;
    string       name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: counts memory strobes and compares each response against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        rd_cnt += int'(mem_memread);
        wr_cnt += int'(mem_memwrite);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
            chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
            chk({e.name, "_latency"}, cyc, e.due);
            chk({e.name, "_memread_cycles"}, rd_cnt, e.rd);
            chk({e.name, "_memwrite_cycles"}, wr_cnt, e.wr);
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee, input int lat,
                       input int rd, input int wr, input string nm, input bit track);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    if (track) begin
      e.rdata = er; e.err = ee; e.due = cyc + lat; e.rd = rd; e.wr = wr; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[11] = 8'h08;
    for (int i = 12; i < 16; i++) mem[i] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    rst = 1'b0;

    //     we sz     uns addr   wdata         exp_rdata     err lat rd wr name
    issue(0, 2'b10, 0, 32'h8, 32'h0,        32'h00000008, 0, 2, 1, 0, "lw_8", 1);
    issue(0, 2'b00, 0, 32'hC, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, "lb_c", 1);
    issue(0, 2'b00, 1, 32'hD, 32'h0,        32'h000000FF, 0, 2, 1, 0, "lbu_d", 1);
    issue(0, 2'b01, 1, 32'hE, 32'h0,        32'h0000FFFF, 0, 2, 1, 0, "lhu_e", 1);
    issue(0, 2'b01, 0, 32'hC, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, "lh_c", 1);
    issue(1, 2'b00, 0, 32'hD, 32'h12,       32'h00000000, 0, 3, 1, 1, "sb_d", 1);
    issue(0, 2'b10, 0, 32'hC, 32'h0,        32'hFF12FFFF, 0, 2, 1, 0, "lw_c_after_sb", 1);
    issue(0, 2'b00, 0, 32'hD, 32'h0,        32'h00000012, 0, 2, 1, 0, "lb_d_pos", 1);
    issue(1, 2'b01, 0, 32'hA, 32'h0000ABCD, 32'h00000000, 0, 3, 1, 1, "sh_a", 1);
    issue(0, 2'b10, 0, 32'h8, 32'h0,        32'h0000ABCD, 0, 2, 1, 0, "lw_8_after_sh", 1);
    issue(0, 2'b01, 0, 32'hA, 32'h0,        32'hFFFFABCD, 0, 2, 1, 0, "lh_a", 1);
    issue(0, 2'b01, 1, 32'h8, 32'h0,        32'h00000000, 0, 2, 1, 0, "lhu_8", 1);
    issue(1, 2'b10, 0, 32'h10, 32'h80FF7F01, 32'h00000000, 0, 2, 0, 1, "sw_10", 1);
    issue(0, 2'b00, 0, 32'h10, 32'h0,       32'hFFFFFF80, 0, 2, 1, 0, "lb_10", 1);
    issue(0, 2'b00, 0, 32'h13, 32'h0,       32'h00000001, 0, 2, 1, 0, "lb_13", 1);
    issue(0, 2'b01, 0, 32'h12, 32'h0,       32'h00007F01, 0, 2, 1, 0, "lh_12", 1);
    issue(0, 2'b00, 1, 32'h11, 32'h0,       32'h000000FF, 0, 2, 1, 0, "lbu_11", 1);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 32'h9, 32'h0,        32'h00000000, 1, 1, 0, 0, "lw_9_trap", 1);
    issue(0, 2'b01, 0, 32'hB, 32'h0,        32'h00000000, 1, 1, 0, 0, "lh_b_trap", 1);
`else
    issue(0, 2'b10, 0, 32'h9, 32'h0,        32'h0000ABCD, 0, 2, 1, 0, "lw_9_aligned", 1);
    issue(0, 2'b01, 0, 32'hB, 32'h0,        32'hFFFFABCD, 0, 2, 1, 0, "lh_b_aligned", 1);
`endif

    // Store interrupted by reset while its write strobe is up
    issue(1, 2'b00, 0, 32'hC, 32'h00, 32'h0, 0, 3, 1, 1, "sb_c_reset", 0);
    guard = 0;
    while (!mem_memwrite && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("reset_wr_reached", {31'd0, mem_memwrite}, 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_memwrite_drop", {31'd0, mem_memwrite}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 2'b10, 0, 32'hC, 32'h0, 32'hFF12FFFF, 0, 2, 1, 0, "lw_c_after_reset", 1);
    issue(0, 2'b00, 0, 32'hC, 32'h0, 32'hFFFFFFFF, 0, 2, 1, 0, "lb_c_after_reset", 1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
